ahb_decoder_mux: RTL and testbench

Parametrised AHB-Lite decoder plus slave-to-master response multiplexor for NO_OF_PERIPHERALS slaves.
- Decodes the address phase from HADDR.
- Registers the data-phase selection on HREADY.
- Routes HRDATA/HREADY/HRESP from the selected slave back to the master.
- Contains a built-in default slave that returns the two-cycle AHB ERROR response for active transfers to unmapped regions, and keeps a saturating error count.
- Sits between the single master and all slaves on the interconnect.

---
 rtl/ahb_decoder_mux.sv | 123 ++++++++++++
 tb/tb_ahb_decoder_mux.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and slave-to-master response multiplexor.
// Includes a default slave that answers unmapped active transfers with a two-cycle ERROR.
module ahb_decoder_mux #(
   parameter int ADDR_WIDTH        = 32,
   parameter int DATA_WIDTH        = 32,
   parameter int NO_OF_PERIPHERALS = 4,
   parameter int P_BITS            = $clog2(NO_OF_PERIPHERALS + 1),
   parameter int ERR_CNT_W         = 8
) (
   input  logic                                    HCLK,
   input  logic                                    HRESET,
   input  logic [ADDR_WIDTH-1:0]                   HADDR,
   input  logic [1:0]                              HTRANS,
   output logic [NO_OF_PERIPHERALS-1:0]            HSEL,
   input  logic [NO_OF_PERIPHERALS-1:0]            HREADYOUT_S,
   input  logic [NO_OF_PERIPHERALS-1:0]            HRESP_S,
   input  logic [NO_OF_PERIPHERALS*DATA_WIDTH-1:0] HRDATA_S,
   output logic                                    HREADY,
   output logic                                    HRESP,
   output logic [DATA_WIDTH-1:0]                   HRDATA,
   output logic [ERR_CNT_W-1:0]                    ERR_CNT
);

   typedef enum logic [1:0] {SEL_NONE, SEL_SLV, SEL_DEF} sel_kind_t;
   typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;

   localparam logic [P_BITS-1:0] N_REGIONS = P_BITS'(NO_OF_PERIPHERALS);

   logic [P_BITS-1:0] idx;
   logic              mapped;
   logic              capture_def;
   sel_kind_t         dsel_kind;
   logic [P_BITS-1:0] dsel_idx;
   dstate_t           state;
   dstate_t           state_next;
   logic              unused_bits;

   assign idx         = HADDR[ADDR_WIDTH-1 -: P_BITS];
   assign mapped      = (idx < N_REGIONS);
   assign capture_def = HREADY && !mapped && HTRANS[1];
   assign unused_bits = ^{HADDR[ADDR_WIDTH-P_BITS-1:0], HTRANS[0]};

   // Address-phase select is purely from HADDR; slaves qualify it themselves.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      HSEL = '0;
      for (int i = 0; i < NO_OF_PERIPHERALS; i++) begin
         if (idx == P_BITS'(i)) HSEL[i] = 1'b1;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (HRESET) begin
         dsel_kind <= SEL_NONE;
         dsel_idx  <= '0;
      end else if (HREADY) begin
         dsel_idx <= idx;
         if (mapped)         dsel_kind <= SEL_SLV;
         else if (HTRANS[1]) dsel_kind <= SEL_DEF;
         else                dsel_kind <= SEL_NONE;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state   <= D_IDLE;
         ERR_CNT <= '0;
      end else begin
         state <= state_next;
         // D_ERR1 always advances to D_ERR2, so this counts each issued ERROR once.
         if (state == D_ERR1 && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         D_IDLE:  if (capture_def) state_next = D_ERR1;
         D_ERR1:  state_next = D_ERR2;
         D_ERR2:  state_next = capture_def ? D_ERR1 : D_IDLE;
         default: state_next = D_IDLE;
      endcase
   end

   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = '0;
      case (dsel_kind)
         SEL_SLV: begin
            for (int i = 0; i < NO_OF_PERIPHERALS; i++) begin
               if (dsel_idx == P_BITS'(i)) begin
                  HREADY = HREADYOUT_S[i];
                  HRESP  = HRESP_S[i];
                  HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
         SEL_DEF: begin
            case (state)
               D_ERR1: begin
                  HREADY = 1'b0;
                  HRESP  = 1'b1;
               end
               D_ERR2: begin
                  HREADY = 1'b1;
                  HRESP  = 1'b1;
               end
               default: begin
                  HREADY = 1'b1;
                  HRESP  = 1'b0;
               end
            endcase
         end
         default: begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed self-checking bench for ahb_decoder_mux with four slaves (P_BITS = 3).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
module tb_ahb_decoder_mux;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int N  = 4;

   logic            clk;
   logic            rst;
   logic [AW-1:0]   haddr;
   logic [1:0]      htrans;
   logic [N-1:0]    hsel;
   logic [N-1:0]    hreadyout_s;
   logic [N-1:0]    hresp_s;
   logic [N*DW-1:0] hrdata_s;
   logic            hready;
   logic            hresp;
   logic [DW-1:0]   hrdata;
   logic [7:0]      err_cnt;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;

   ahb_decoder_mux #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_OF_PERIPHERALS(N), .ERR_CNT_W(8)
   ) dut (
      .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel),
      .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
      .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata), .ERR_CNT(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic park();
      haddr  = 32'hE000_0000;
      htrans = IDLE;
   endtask

   // Continuous protocol sanity: HSEL never multi-hot, HREADY never unknown.
   always @(negedge clk) begin
      check("hsel_onehot0", {31'd0, $onehot0(hsel)}, 32'd1);
      check("hready_known", {31'd0, $isunknown(hready)}, 32'd0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst         = 1'b1;
      haddr       = 32'h4000_0000;
      htrans      = IDLE;
      hreadyout_s = '1;
      hresp_s     = '0;
      hrdata_s    = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};

      // Reset state; 0x4000_0000 has region index 2.
      #3;
      check("rst_hready", {31'd0, hready}, 32'd1);
      check("rst_hresp",  {31'd0, hresp},  32'd0);
      check("rst_hrdata", hrdata,          32'd0);
      check("rst_errcnt", {24'd0, err_cnt}, 32'd0);
      check("rst_hsel",   {28'd0, hsel},   32'h4);
      step();
      step();
      rst = 1'b0;
      park();

      // Slave 1 read with two wait states.
      haddr  = 32'h2000_0010;
      htrans = NONSEQ;
      #1 check("s1_hsel", {28'd0, hsel}, 32'h2);
      step();
      park();
      hreadyout_s[1] = 1'b0;
      #1 check("s1_wait1", {31'd0, hready}, 32'd0);
      step();
      #1 check("s1_wait2", {31'd0, hready}, 32'd0);
      hreadyout_s[1] = 1'b1;
      #1;
      check("s1_ready", {31'd0, hready}, 32'd1);
      check("s1_data",  hrdata,          32'hDEAD_BEEF);
      check("s1_resp",  {31'd0, hresp},  32'd0);
      step();

      // Unmapped NONSEQ: two-cycle ERROR.
      haddr  = 32'hA000_0000;
      htrans = NONSEQ;
      #1 check("um_hsel", {28'd0, hsel}, 32'h0);
      step();
      park();
      #1;
      check("um_e1_ready", {31'd0, hready}, 32'd0);
      check("um_e1_resp",  {31'd0, hresp},  32'd1);
      check("um_e1_data",  hrdata,          32'd0);
      step();
      #1;
      check("um_e2_ready", {31'd0, hready}, 32'd1);
      check("um_e2_resp",  {31'd0, hresp},  32'd1);
      check("um_e2_cnt",   {24'd0, err_cnt}, 32'd1);

      // IDLE to unmapped 0xE000_0000 (captured on this edge): OKAY, no count.
      step();
      #1;
      check("idle_ready", {31'd0, hready}, 32'd1);
      check("idle_resp",  {31'd0, hresp},  32'd0);
      step();
      #1 check("idle_cnt", {24'd0, err_cnt}, 32'd1);

      // Back-to-back: unmapped NONSEQ, then slave 0 at 0x0000_0004 held during ERROR.
      haddr  = 32'hA000_0000;
      htrans = NONSEQ;
      step();
      haddr  = 32'h0000_0004;
      htrans = NONSEQ;
      #1 check("b2b_e1_ready", {31'd0, hready}, 32'd0);
      step();
      #1;
      check("b2b_e2_ready", {31'd0, hready}, 32'd1);
      check("b2b_e2_resp",  {31'd0, hresp},  32'd1);
      check("b2b_e2_cnt",   {24'd0, err_cnt}, 32'd2);
      step();
      park();
      #1;
      check("b2b_s0_ready", {31'd0, hready}, 32'd1);
      check("b2b_s0_resp",  {31'd0, hresp},  32'd0);
      check("b2b_s0_data",  hrdata,          32'h1111_0000);
      step();

      // Slave 2 ERROR response passes through the mux.
      haddr      = 32'h4000_0000;
      htrans     = NONSEQ;
      hresp_s[2] = 1'b1;
      step();
      park();
      #1;
      check("s2_resp", {31'd0, hresp}, 32'd1);
      check("s2_data", hrdata,         32'h2222_2222);
      hresp_s[2] = 1'b0;
      step();

      // Continuous unmapped NONSEQ: ERR2 -> ERR1 chaining up to saturation.
      haddr  = 32'hA000_0000;
      htrans = NONSEQ;
      step();
      for (int k = 0; k < 253; k++) begin
         step();
         step();
      end
      #1;
      check("sat_cnt_ff", {24'd0, err_cnt}, 32'hFF);
      check("sat_e1_ready", {31'd0, hready}, 32'd0);
      step();
      park();
      #1;
      check("sat_e2_resp", {31'd0, hresp}, 32'd1);
      check("sat_cnt_hold", {24'd0, err_cnt}, 32'hFF);
      step();
      step();
      #1 check("sat_cnt_final", {24'd0, err_cnt}, 32'hFF);

      // Reset during D_ERR1 forces OKAY immediately.
      haddr  = 32'hA000_0000;
      htrans = NONSEQ;
      step();
      #1 check("rerr_e1_ready", {31'd0, hready}, 32'd0);
      rst = 1'b1;
      #1;
      check("rerr_ready", {31'd0, hready}, 32'd1);
      check("rerr_resp",  {31'd0, hresp},  32'd0);
      check("rerr_cnt",   {24'd0, err_cnt}, 32'd0);
      park();
      step();
      rst = 1'b0;
      haddr  = 32'h6000_0008;
      htrans = NONSEQ;
      #1 check("rerr_hsel", {28'd0, hsel}, 32'h8);
      step();
      park();
      #1;
      check("rerr_s3_ready", {31'd0, hready}, 32'd1);
      check("rerr_s3_resp",  {31'd0, hresp},  32'd0);
      check("rerr_s3_data",  hrdata,          32'h3333_3333);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
